// File: rtl/pc_next_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit_if
// Description : Bus between the control/branch logic (master) and the
//               program-counter sequencer (slave).
//   master drives : Stall, PCSrc, Jump, JumpReg, Exc, ExcCode, Eret,
//                   PCBranch, RegTarget, Instr
//   slave drives  : PC, PCPlus4, EPC, Cause, EXL, InstrCount
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_next_unit_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  // Requests toward the sequencer
  logic                 Stall;
  logic                 PCSrc;
  logic                 Jump;
  logic                 JumpReg;
  logic                 Exc;
  logic [4:0]           ExcCode;
  logic                 Eret;
  logic [WIDTH-1:0]     PCBranch;
  logic [WIDTH-1:0]     RegTarget;
  logic [WIDTH-1:0]     Instr;

  // Sequencer state visible to the rest of the core
  logic [WIDTH-1:0]     PC;
  logic [WIDTH-1:0]     PCPlus4;
  logic [WIDTH-1:0]     EPC;
  logic [4:0]           Cause;
  logic                 EXL;
  logic [CNT_WIDTH-1:0] InstrCount;

  modport master (
    output Stall, PCSrc, Jump, JumpReg, Exc, ExcCode, Eret,
           PCBranch, RegTarget, Instr,
    input  PC, PCPlus4, EPC, Cause, EXL, InstrCount
  );

  modport slave (
    input  Stall, PCSrc, Jump, JumpReg, Exc, ExcCode, Eret,
           PCBranch, RegTarget, Instr,
    output PC, PCPlus4, EPC, Cause, EXL, InstrCount
  );
endinterface
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : MIPS program-counter sequencer. Holds the architectural PC
//               and picks the next PC from sequential, branch, jump,
//               jump-register, exception-vector and exception-return
//               sources. Captures EPC/Cause on exception entry, tracks the
//               exception level (EXL) and counts retired instructions.
// Ports       :
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pc_next_unit_if.slave (control requests in, PC state out)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int               CNT_WIDTH    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_next_unit_if.slave bus
);

  // Exception-level state encoding
  localparam logic [0:0] S_NORMAL    = 1'b0;
  localparam logic [0:0] S_EXCEPTION = 1'b1;

  // AdEL: address error on instruction fetch
  localparam logic [4:0] CAUSE_ADEL  = 5'd4;

  logic [0:0]           state;
  logic [0:0]           state_next;

  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     epc;
  logic [4:0]           cause;
  logic [CNT_WIDTH-1:0] instr_count;

  logic [WIDTH-1:0]     pc_plus4;
  logic [WIDTH-1:0]     jump_target;
  logic [WIDTH-1:0]     next_pc;
  logic                 addr_err;
  logic                 exc_entry;
  logic                 eret_take;
  logic [4:0]           cause_next;
  logic                 exl;

  // Only the low 26 instruction bits form the jump index.
  logic                 unused_instr_bits;
  assign unused_instr_bits = ^bus.Instr[WIDTH-1:26];

  // --------------------------------------------------------------------------
  // Next-PC datapath
  // --------------------------------------------------------------------------
  assign pc_plus4    = pc + WIDTH'(4);
  assign jump_target = {pc_plus4[WIDTH-1:28], bus.Instr[25:0], 2'b00};

  // A misaligned JR target faults instead of being fetched.
  assign addr_err    = bus.JumpReg && (bus.RegTarget[1:0] != 2'b00);
  assign exc_entry   = !bus.Stall && (bus.Exc || addr_err);

  // Eret only acts inside the handler and loses to any exception entry;
  // outside the handler it falls through to lower-priority sources.
  assign eret_take   = !bus.Stall && !exc_entry && bus.Eret && (state == S_EXCEPTION);

  // Explicit Exc outranks the address error for the recorded cause.
  assign cause_next  = bus.Exc ? bus.ExcCode : CAUSE_ADEL;

  always_comb begin
    next_pc = pc_plus4;
    if (bus.Stall) begin
      next_pc = pc;
    end else if (exc_entry) begin
      next_pc = EXC_VECTOR;
    end else if (eret_take) begin
      next_pc = epc;
    end else if (bus.JumpReg) begin
      next_pc = bus.RegTarget;
    end else if (bus.Jump) begin
      next_pc = jump_target;
    end else if (bus.PCSrc) begin
      next_pc = bus.PCBranch;
    end
  end

  // --------------------------------------------------------------------------
  // PC, EPC, Cause and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      epc         <= '0;
      cause       <= '0;
      instr_count <= '0;
    end else if (!bus.Stall) begin
      pc <= next_pc;
      if (exc_entry) begin
        cause <= cause_next;
        // A nested exception keeps the original return address.
        if (state == S_NORMAL) begin
          epc <= pc;
        end
      end else begin
        instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Exception-level state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_NORMAL: begin
        if (exc_entry) begin
          state_next = S_EXCEPTION;
        end
      end
      S_EXCEPTION: begin
        if (eret_take) begin
          state_next = S_NORMAL;
        end
      end
      default: state_next = S_NORMAL;
    endcase
  end

  always_comb begin
    exl = 1'b0;
    case (state)
      S_NORMAL:    exl = 1'b0;
      S_EXCEPTION: exl = 1'b1;
      default:     exl = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.PC         = pc;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.EPC        = epc;
  assign bus.Cause      = cause;
  assign bus.EXL        = exl;
  assign bus.InstrCount = instr_count;

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter sequencer for the MIPS core: holds the architectural PC and selects the next PC from sequential, branch, jump, jump-register, exception-vector and exception-return sources. Adds pipeline-ready stall, precise exception entry with EPC/Cause capture, an exception-level (EXL) state machine and a retired-instruction counter. It sits between the control unit/ALU branch logic and instruction memory, and replaces the single-mode PC register.

## Interface
- WIDTH, 32, address/data width; legal values are ≥ 32.
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception entry.
- CNT_WIDTH, 32, width of the retired-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Stall  in  1  holds all state for this cycle.
- PCSrc  in  1  taken branch.
- Jump  in  1  J/JAL.
- JumpReg  in  1  JR/JALR.
- Exc  in  1  external exception request.
- ExcCode  in  5  cause code for Exc.
- Eret  in  1  return from exception.
- PCBranch  in  WIDTH  branch target.
- RegTarget  in  WIDTH  register-sourced target for JumpReg.
- Instr  in  WIDTH  current instruction.
- PC  out  WIDTH  current PC (registered).
- PCPlus4  out  WIDTH  PC + 4, combinational, modulo 2^WIDTH.
- EPC  out  WIDTH  exception PC (registered).
- Cause  out  5  last exception code (registered).
- EXL  out  1  exception level; 1 = in handler.
- InstrCount  out  CNT_WIDTH  retired-instruction count.

## Operation
- Reset values: PC=RESET_VECTOR, EPC=0, Cause=0, EXL=0, InstrCount=0.
- Jump target: {PCPlus4[WIDTH-1:28], Instr[25:0], 2'b00}.
- Next-PC priority, highest first:
  1. Stall: hold PC, EPC, Cause, EXL and InstrCount.
  2. Exc.
  3. Address error: JumpReg=1 and RegTarget[1:0]≠0.
  4. Eret.
  5. JumpReg.
  6. Jump.
  7. PCSrc.
  8. PCPlus4.
- Exception entry (Exc, or address error):
  - PC ← EXC_VECTOR.
  - Cause ← ExcCode for Exc, or 5'd4 (AdEL) for address error.
  - If EXL=0: EPC ← PC and EXL ← 1.
  - If EXL=1 (nested exception): EPC and EXL are unchanged, Cause is updated.
- Eret:
  - If EXL=1: PC ← EPC, EXL ← 0.
  - If EXL=0: Eret is ignored; the next PC falls through to lower-priority sources.
- EXL state machine:
  - NORMAL (EXL=0) → EXCEPTION on exception entry.
  - EXCEPTION (EXL=1) → NORMAL on an accepted Eret.
  - No other transitions.
- InstrCount increments by 1 on every non-stalled cycle in which no exception entry occurs; it wraps at 2^CNT_WIDTH.
- Control inputs may be asserted together; only the highest-priority source takes effect.

## Timing
- All registered outputs update one cycle after the inputs are sampled at the rising edge.
- PCPlus4 is combinational from PC and valid in the same cycle.
- Zero-cycle redirect: the target selected in cycle N is the PC in cycle N+1.
- Stall has no latency. Requests present while stalled are dropped; the source must hold them until Stall=0.
- An rst_n assertion at any time forces the reset values immediately, independent of clk. Deassertion is synchronized externally.
- PC wrap: PC = 2^WIDTH−4 with no redirect gives a next PC of 0.

## Test plan
- Reset: hold rst_n=0 mid-run with PC=0x40 → PC=0, EPC=0, EXL=0, InstrCount=0 asynchronously. After release, PC steps 0→4→8 and InstrCount=2 after 2 cycles.
- Branch and jump: PC=0x1000, PCSrc=1, PCBranch=0x2000 → PC=0x2000. Then Jump=1 with Instr[25:0]=0x0000100 → PC=0x0000_0400. Then Stall=1 for 3 cycles → PC stays 0x400 and InstrCount is frozen.
- Exception round trip: PC=0x3000, Exc=1, ExcCode=8 → PC=0x180, EPC=0x3000, Cause=8, EXL=1, InstrCount unchanged. Then Eret → PC=0x3000, EXL=0.
- Nested exception and ignored Eret:
  - With EXL=1, EPC=0x3000, raise Exc with ExcCode=12 → PC=0x180, EPC stays 0x3000, Cause=12.
  - With EXL=0 and PC=0x10, Eret → PC=0x14.
- Address error: JumpReg=1, RegTarget=0x2002, PC=0x500 → PC=0x180, EPC=0x500, Cause=4. With RegTarget=0x2000 instead → PC=0x2000.
- Priority and wrap:
  - Exc, Jump and PCSrc asserted together → exception taken.
  - Stall and Exc asserted together → no change.
  - PC=0xFFFF_FFFC → next PC=0.
